// File: rtl/twiddle_gen.sv
// FFT twiddle-factor generator: streams W_N^k = cos - j*sin for k = m << stage,
// built from a quarter-wave cosine table with one-cycle registered output.
module twiddle_gen #(
  parameter  int N     = 32,
  parameter  int W     = 9,
  parameter  int FRAC  = 7,
  localparam int LOG2N = $clog2(N),
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SW-1:0]       stage,
  input  logic                en,
  input  logic                cont,
  output logic signed [W-1:0] w_r,
  output logic signed [W-1:0] w_i,
  output logic                w_valid,
  output logic                last,
  output logic                active
);

  localparam int MW = LOG2N - 1;  // m spans 0..N/2-1
  localparam int Q  = N / 4;

  // Quarter-wave cosine at 64-point resolution, floor(cos*2^16); shifting down
  // keeps trunc-toward-zero exact for any FRAC up to 16.
  function automatic logic signed [W-1:0] c_val(input int j);
    int q16;
    case (j * (64 / N))
      0:  q16 = 65536;
      1:  q16 = 65220;
      2:  q16 = 64276;
      3:  q16 = 62714;
      4:  q16 = 60547;
      5:  q16 = 57797;
      6:  q16 = 54491;
      7:  q16 = 50660;
      8:  q16 = 46340;
      9:  q16 = 41575;
      10: q16 = 36409;
      11: q16 = 30893;
      12: q16 = 25079;
      13: q16 = 19024;
      14: q16 = 12785;
      15: q16 = 6423;
      default: q16 = 0;
    endcase
    return W'(q16 >>> (16 - FRAC));
  endfunction

  logic [SW-1:0]       s_q;
  logic [MW-1:0]       m;
  logic [MW-1:0]       m_last;
  logic [SW-1:0]       s_clamp;
  logic [LOG2N-1:0]    k;
  logic [LOG2N-1:0]    kp;
  logic signed [W-1:0] r_next;
  logic signed [W-1:0] i_next;

  assign s_clamp = (int'(stage) > LOG2N - 1) ? SW'(LOG2N - 1) : stage;
  assign m_last  = MW'((N >> (int'(s_q) + 1)) - 1);
  assign k       = LOG2N'(m) << s_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    kp     = '0;
    r_next = '0;
    i_next = '0;
    if (int'(k) < Q) begin
      r_next = c_val(int'(k));
      i_next = -c_val(Q - int'(k));
    end else begin
      kp     = k - LOG2N'(Q);
      r_next = -c_val(Q - int'(kp));
      i_next = -c_val(int'(kp));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      m       <= '0;
      active  <= 1'b0;
      w_r     <= '0;
      w_i     <= '0;
      w_valid <= 1'b0;
      last    <= 1'b0;
    end else if (start) begin
      // start wins over en: re-arm without issuing, aborting any pass in flight
      s_q     <= s_clamp;
      m       <= '0;
      active  <= 1'b1;
      w_valid <= 1'b0;
      last    <= 1'b0;
    end else if (active && en) begin
      w_r     <= r_next;
      w_i     <= i_next;
      w_valid <= 1'b1;
      last    <= (m == m_last);
      if (m == m_last) begin
        m <= '0;
        if (!cont) active <= 1'b0;
      end else begin
        m <= m + MW'(1);
      end
    end else begin
      w_valid <= 1'b0;
      last    <= 1'b0;
    end
  end

endmodule

// File: doc/twiddle_gen.md
TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter N, default 32, meaning FFT points; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter W, default 9, meaning signed coefficient width; W >= FRAC+2.
REQ-003 SHALL have parameter FRAC, default 7, meaning fraction bits (1.0 = 2^FRAC = 128).
REQ-004 SHALL have localparam LOG2N = log2(N) and SW = max(1, clog2(LOG2N)).
REQ-005 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse that latches stage, clears the index counter and sets active.
REQ-008 SHALL have port stage  input  SW  FFT stage (0 = first), sampled only when start=1.
REQ-009 SHALL have port en  input  1  advance request; one twiddle is issued per cycle with en=1 while active.
REQ-010 SHALL have port cont  input  1  when 1, the sequence wraps indefinitely; when 0, it stops after one pass.
REQ-011 SHALL have port w_r  output  W  signed real part of W_N^k.
REQ-012 SHALL have port w_i  output  W  signed imaginary part of W_N^k.
REQ-013 SHALL have port w_valid  output  1  w_r and w_i are valid this cycle.
REQ-014 SHALL have port last  output  1  asserted with the final twiddle of a pass.
REQ-015 SHALL have port active  output  1  generator is armed.

Function
REQ-016 SHALL hold a quarter-wave table C[j], j = 0..N/4, where C[j] = trunc-toward-zero(2^FRAC*cos(2*pi*j/N)); for N=32: 128,125,118,106,90,71,48,24,0.
REQ-017 SHALL compute k = m << s for the latched stage s = min(stage, LOG2N-1) and the counter m = 0..L/2-1, where L = N >> s.
REQ-018 SHALL produce, for k < N/4, w_r = C[k] and w_i = -C[N/4-k].
REQ-019 SHALL produce, for k >= N/4 with k' = k-N/4, w_r = -C[N/4-k'] and w_i = -C[k'].
REQ-020 SHALL issue one twiddle on the cycle with active=1 and en=1, present it registered on the next cycle with w_valid=1 (latency 1), then increment m.
REQ-021 SHALL drive w_valid=0 on every cycle with no issue, holding w_r and w_i at their last values.
REQ-022 SHALL assert last, coincident with w_valid, for the twiddle where m = L/2-1.
REQ-023 SHALL wrap m from L/2-1 to 0 on issue; if cont=0 at that issue, active SHALL clear on the next cycle; if cont=1, active SHALL stay set.
REQ-024 SHALL treat start as taking priority over en in the same cycle: m=0, stage latched, active=1, no twiddle issued that cycle.
REQ-025 SHALL restart from m=0 with the newly latched stage when start arrives while active; no completion pulse is generated for the aborted pass.
REQ-026 SHALL ignore en while active=0, issuing nothing and leaving m unchanged.
REQ-027 SHALL, when s = LOG2N-1 (L/2 = 1), output k=0 (128, 0) with last=1 on every issue.
REQ-028 SHALL keep all negations in W bits; C[0]=2^FRAC negated SHALL fit without overflow (guaranteed by W >= FRAC+2).

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force w_r=0, w_i=0, w_valid=0, last=0, active=0, m=0 and the latched stage to 0.
REQ-030 SHALL, after rst_n deasserts, require a start before any twiddle is issued; reset mid-pass SHALL discard the pass.

Verification (N=32, W=9, FRAC=7)
REQ-031 SHALL cover: start with stage=0, cont=0, en held high -> 16 valid twiddles; m=4 gives (90,-90), m=8 gives (0,-128), m=12 gives (-90,-90); last on m=15; active=0 afterwards.
REQ-032 SHALL cover: stage=1, en high -> 8 twiddles with k=0,2,..,14; m=6 gives (-90,-90); last on the 8th twiddle.
REQ-033 SHALL cover: stage=4 with cont=1 -> every issue gives (128,0) with last=1; active stays 1.
REQ-034 SHALL cover: en toggling 1,0,1 -> w_valid pattern 0,1,0,1 one cycle later; outputs held during the gap; no index skipped.
REQ-035 SHALL cover: start asserted at m=5 of stage 0 with stage=2 -> next issue is k=0 of stage 2; no last for the aborted pass.
REQ-036 SHALL cover: rst_n low mid-pass -> all outputs 0 immediately (asynchronous); en after release yields no w_valid until start.
